slot_fifo: RTL and testbench

- Single-clock byte FIFO that buffers host (FX2) audio bytes for one converter slot.
- The host/FX2 interface logic writes bytes in. The slot's DAC module pulls bytes out through its fifo_clk/fifo_read/fifo_data/fifo_addr_in/fifo_addr_out connection.
- Read data is registered: a byte is valid one cycle after the read strobe. This matches a consumer that delays its read strobe by one cycle before capturing.
- Also provides full/empty/fill count and sticky overflow/underflow flags for status readback.

---
 rtl/slot_fifo.sv | 136 +++++++++++++
 tb/tb_slot_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/slot_fifo.sv
// Single-clock byte FIFO buffering host audio bytes for one converter slot.
// Optional: define SLOT_FIFO_UNDERRUN_ZERO_EN to output zero on a rejected read.
module slot_fifo #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_flags
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic rd_ok;
  logic wr_ok;
  logic rd_reject;
  logic wr_reject;

  // Flush suppresses all traffic; reset is handled in the register process.
  always_comb begin
    rd_ok     = rd_en && !empty_q && !flush;
    wr_ok     = wr_en && (!full_q || (rd_en && !empty_q)) && !flush;
    rd_reject = rd_en && empty_q && !flush;
    wr_reject = wr_en && !wr_ok && !flush;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_data_d = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
`ifdef SLOT_FIFO_UNDERRUN_ZERO_EN
      if (rd_reject) begin
        rd_data_d = '0;
      end
`endif
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // A new event in the same cycle wins over clear_flags.
      if (clear_flags) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end
      if (wr_reject) begin
        overflow_d = 1'b1;
      end
      if (rd_reject) begin
        underflow_d = 1'b1;
      end
    end

    // Count never exceeds Depth, so its MSB alone marks full.
    full_d  = count_d[ADDR_WIDTH];
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; the read above sees the pre-write byte (read-first).
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign addr_in   = wr_ptr_q[ADDR_WIDTH-1:0];
  assign addr_out  = rd_ptr_q[ADDR_WIDTH-1:0];
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_slot_fifo.sv
// Directed bench for slot_fifo: read data is scoreboarded, status is checked inline.
module tb_slot_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic [10:0] addr_in;
  logic [10:0] addr_out;
  logic        flush;
  logic        full;
  logic        empty;
  logic [11:0] count;
  logic        overflow;
  logic        underflow;
  logic        clear_flags;

  logic        exp_rd = 1'b0;
  logic        pend = 1'b0;
  logic [7:0]  sb_q [$];
  int          errors = 0;
  int          checks = 0;

  slot_fifo #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .addr_in    (addr_in),
    .addr_out   (addr_out),
    .flush      (flush),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow),
    .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: rd_data is compared on the negedge after each expected read strobe.
  always @(posedge clk) pend <= exp_rd;

  always @(negedge clk) begin
    if (pend) begin
      if (sb_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL rd_data: read with no expected byte, got 0x%0h", rd_data);
      end else begin
        check("rd_data", {24'd0, rd_data}, {24'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clear_flags = 1'b0;
    exp_rd = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] d);
    idle(); wr_en = 1'b1; wr_data = d; step();
  endtask

  task automatic do_read(input logic [7:0] e);
    idle(); rd_en = 1'b1; exp_rd = 1'b1; sb_q.push_back(e); step();
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; step(); step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " count"}, {20'd0, count}, 32'd0);
    check({tag, " empty"}, {31'd0, empty}, 32'd1);
    check({tag, " full"}, {31'd0, full}, 32'd0);
    check({tag, " overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, " underflow"}, {31'd0, underflow}, 32'd0);
    check({tag, " rd_data"}, {24'd0, rd_data}, 32'd0);
    check({tag, " addr_in"}, {21'd0, addr_in}, 32'd0);
    check({tag, " addr_out"}, {21'd0, addr_out}, 32'd0);
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] und_exp;
    wr_data = 8'h00;
    idle();
    reset = 1'b1;
    step(); step();
    check_reset_state("reset");

    // Basic four-byte round trip.
    do_write(8'h11); do_write(8'h22); do_write(8'h33); do_write(8'h44);
    idle(); step();
    check("count4", {20'd0, count}, 32'd4);
    check("addr_in4", {21'd0, addr_in}, 32'd4);
    do_read(8'h11); do_read(8'h22); do_read(8'h33); do_read(8'h44);
    idle(); step();
    check("rt addr_in", {21'd0, addr_in}, 32'd4);
    check("rt addr_out", {21'd0, addr_out}, 32'd4);
    check("rt count", {20'd0, count}, 32'd0);
    check("rt empty", {31'd0, empty}, 32'd1);

    // Fill to 2048, then one dropped write.
    do_reset();
    for (int i = 0; i < 2048; i++) do_write(i[7:0]);
    idle(); step();
    check("fill full", {31'd0, full}, 32'd1);
    check("fill count", {20'd0, count}, 32'd2048);
    check("fill addr_in", {21'd0, addr_in}, 32'd0);
    check("fill ovf pre", {31'd0, overflow}, 32'd0);
    do_write(8'hEE);
    idle(); step();
    check("drop overflow", {31'd0, overflow}, 32'd1);
    check("drop count", {20'd0, count}, 32'd2048);
    check("drop addr_in", {21'd0, addr_in}, 32'd0);
    idle(); clear_flags = 1'b1; step();
    check("clr overflow", {31'd0, overflow}, 32'd0);

    // Full with simultaneous read and write: read-first gives old byte 0x00.
    idle(); rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'hAA; exp_rd = 1'b1;
    sb_q.push_back(8'h00); step();
    idle(); step();
    check("rw full count", {20'd0, count}, 32'd2048);
    check("rw full ovf", {31'd0, overflow}, 32'd0);
    check("rw full full", {31'd0, full}, 32'd1);
    check("rw addr_out", {21'd0, addr_out}, 32'd1);
    for (int i = 1; i < 2048; i++) do_read(i[7:0]);
    do_read(8'hAA);
    idle(); step();
    check("drain empty", {31'd0, empty}, 32'd1);
    check("drain count", {20'd0, count}, 32'd0);
    check("drain unf", {31'd0, underflow}, 32'd0);

    // Empty with simultaneous read and write: write only, no bypass.
    prev = 8'hAA;
`ifdef SLOT_FIFO_UNDERRUN_ZERO_EN
    und_exp = 8'h00;
`else
    und_exp = prev;
`endif
    idle(); rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'h5C; exp_rd = 1'b1;
    sb_q.push_back(und_exp); step();
    idle(); step();
    check("rw empty unf", {31'd0, underflow}, 32'd1);
    check("rw empty count", {20'd0, count}, 32'd1);
    check("rw empty ovf", {31'd0, overflow}, 32'd0);
    do_read(8'h5C);
    idle(); step();
    check("post 5C empty", {31'd0, empty}, 32'd1);

    // Flush with 10 bytes stored.
    for (int i = 0; i < 10; i++) do_write(8'h30 + i[7:0]);
    idle(); step();
    check("pre flush count", {20'd0, count}, 32'd10);
    idle(); flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hFF; step();
    check("flush count", {20'd0, count}, 32'd0);
    check("flush empty", {31'd0, empty}, 32'd1);
    check("flush addr_in", {21'd0, addr_in}, 32'd0);
    check("flush addr_out", {21'd0, addr_out}, 32'd0);
    check("flush ovf", {31'd0, overflow}, 32'd0);
    check("flush unf", {31'd0, underflow}, 32'd1);
    check("flush rd_data", {24'd0, rd_data}, 32'h5C);
    // Event in the same cycle as clear_flags keeps the flag set.
    idle(); clear_flags = 1'b1; rd_en = 1'b1; step();
    check("clr race unf", {31'd0, underflow}, 32'd1);
    idle(); clear_flags = 1'b1; step();
    check("clr unf", {31'd0, underflow}, 32'd0);
    check("clr ovf", {31'd0, overflow}, 32'd0);

    // Reset mid-burst with 100 bytes stored and traffic in the reset cycle.
    for (int i = 0; i < 100; i++) do_write(i[7:0] ^ 8'h5A);
    do_read(8'h5A);
    idle(); step();
    check("pre reset count", {20'd0, count}, 32'd99);
    idle(); reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99; step();
    check_reset_state("midreset");
    do_write(8'h77);
    do_read(8'h77);
    idle(); step();
    check("final empty", {31'd0, empty}, 32'd1);
    check("final addr_out", {21'd0, addr_out}, 32'd1);
    check("scoreboard drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
